apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

APB master bridge that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the memory-backed APB slave. It sits directly upstream of the slave and drives psel/penable/pwrite/paddr/pwdata. It waits out the slave's variable pready latency and returns one response per command: read data or write completion, plus an error flag on timeout.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 15, max ACCESS cycles with pready low before abort; 0 disables timeout
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o at rising edge
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  transfer address
- cmd_wdata_i  in  DATA_W  write data (ignored for reads)
- rsp_valid_o  out  1  one-cycle response pulse, no backpressure
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors; held until next response
- rsp_err_o  out  1  response is a timeout abort; qualified by rsp_valid_o
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- paddr_o  out  ADDR_W  APB address
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data, sampled on completion
- pready_i  in  1  APB transfer complete, sampled in ACCESS only

## Operation
- FSM states: IDLE (psel=0, penable=0), SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
- IDLE: cmd_ready_o=1. On accept, latch write/addr/wdata into the command register and go to SETUP.
- SETUP: always lasts exactly one cycle, then goes to ACCESS. cmd_ready_o=0.
- ACCESS with pready_i=1 (completion):
  - If cmd_valid_i is high in the same cycle, cmd_ready_o=1, the new command is latched, and the next state is SETUP (psel stays 1, penable drops).
  - Otherwise the next state is IDLE.
- ACCESS with pready_i=0: stay in ACCESS and increment the wait counter. cmd_ready_o=0.
- Timeout: when the wait counter equals TIMEOUT (TIMEOUT>0) and pready_i=0, abort the transfer:
  - Next state is IDLE, with cmd_ready_o=0 that cycle.
  - Response has err=1 and rdata=0.
- Wait counter: width $clog2(TIMEOUT+1), minimum 1 bit. Cleared on entry to SETUP, saturates, never wraps.
- paddr_o, pwrite_o and pwdata_o come straight from the command register. They are stable from SETUP through the last ACCESS cycle. pwdata_o is 0 for reads.
- Response: registered. rsp_valid_o pulses in the cycle after completion or abort.
  - Read: rsp_rdata_o = prdata_i sampled at the completion edge.
  - Write: rsp_rdata_o = 0, rsp_err_o = 0.
- pready_i is ignored in IDLE and SETUP.

## Timing
- Reset values: every output is 0 except cmd_ready_o. cmd_ready_o reads 1 once out of reset, because the FSM resets to IDLE. The command register and wait counter are 0.
- Reset asserted mid-transfer:
  - psel_o and penable_o drop asynchronously.
  - The in-flight command is dropped and no response is issued.
- Zero-wait transfer: accept at edge N; SETUP in cycle N..N+1; ACCESS in cycle N+1..N+2 with pready=1; rsp_valid_o high in cycle N+2..N+3.
  - Minimum command-to-response latency is 3 cycles.
  - Peak throughput is one transfer per 2 cycles.
- Each ACCESS cycle with pready=0 adds one cycle of latency.
- Timeout response arrives 2+TIMEOUT+1 cycles after accept.
- cmd_ready_o is combinational from state, pready_i and the timeout condition. It never depends combinationally on cmd_valid_i.

## Test plan
- Reset → psel/penable/rsp_valid=0, cmd_ready=1. Assert rst mid-ACCESS → psel/penable drop immediately, no rsp_valid afterwards.
- Write addr 0x10, data 0xDEADBEEF, pready tied 1 → pwrite=1, paddr=0x10 stable over SETUP+ACCESS. rsp_valid 3 cycles after accept, rdata=0, err=0.
- Read addr 0x10, pready low for 4 ACCESS cycles, prdata=0xDEADBEEF on the completion cycle → penable high for 5 cycles, rsp_rdata=0xDEADBEEF, response 7 cycles after accept.
- Back-to-back: cmd_valid held with 3 commands (W 0x01, W 0x02, R 0x01), pready=1 → psel never drops between transfers, penable toggles 0/1, 3 responses at 2-cycle spacing.
- Timeout: TIMEOUT=15, pready stuck 0 → exactly 16 ACCESS cycles, then psel=0, rsp_valid with err=1, rdata=0. A following command completes normally.
- TIMEOUT=0, pready low for 100 cycles then high → no abort, normal response with err=0.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB master bridge: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one registered response per command (timeout aborts flagged).
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                ready;
  logic                load;
  logic                timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign timeout = (TIMEOUT > 0) && (state_q == ACCESS) && !pready_i && (cnt_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ready       = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (cmd_valid_i) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          ready       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : prdata_i;
          rsp_err_d   = 1'b0;
          if (cmd_valid_i) begin
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout) begin
          // Abort: ready stays low so no command slips in on the abort edge.
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      write_d = cmd_write_i;
      addr_d  = cmd_addr_i;
      wdata_d = cmd_write_i ? cmd_wdata_i : '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = ready;
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = write_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: scoreboard of expected responses plus per-scenario tasks;
// a second instance with TIMEOUT=0 covers the disabled-timeout case.
module tb_apb_master_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, prdata = '0;
  logic        pready = 1'b0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o;
  logic [31:0] rsp_rdata_o, pwdata_o;
  logic [7:0]  paddr_o;

  logic        z_valid = 1'b0, z_write = 1'b0;
  logic [7:0]  z_addr = '0;
  logic [31:0] z_wdata = '0, z_prdata = '0;
  logic        z_pready = 1'b0;
  logic        z_ready, z_rsp_valid, z_rsp_err, z_psel, z_penable, z_pwrite;
  logic [31:0] z_rsp_rdata, z_pwdata;
  logic [7:0]  z_paddr;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready)
  );

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid_i(z_valid), .cmd_ready_o(z_ready), .cmd_write_i(z_write),
    .cmd_addr_i(z_addr), .cmd_wdata_i(z_wdata),
    .rsp_valid_o(z_rsp_valid), .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err),
    .psel_o(z_psel), .penable_o(z_penable), .pwrite_o(z_pwrite),
    .paddr_o(z_paddr), .pwdata_o(z_pwdata), .prdata_i(z_prdata), .pready_i(z_pready)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard consumer: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid_o) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b at cyc %0d, required no response",
                 rsp_rdata_o, rsp_err_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_rdata_o !== mon_e.rdata || rsp_err_o !== mon_e.err || cyc !== mon_e.due) begin
          fails++;
          $display("FAIL rsp_match: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                   rsp_rdata_o, rsp_err_o, cyc, mon_e.rdata, mon_e.err, mon_e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({psel_o, penable_o, rsp_valid_o, rsp_err_o, pwrite_o} !== 5'b0 ||
        paddr_o !== 8'h0 || pwdata_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got psel=%b pen=%b rv=%b err=%b pw=%b paddr=%h pwdata=%h rdata=%h, required all 0",
               psel_o, penable_o, rsp_valid_o, rsp_err_o, pwrite_o, paddr_o, pwdata_o, rsp_rdata_o);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", cmd_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] a;
    logic        bad;
    bad = 1'b0;
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
    tests++;
    if (cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL write_ready: got %b, required 1", cmd_ready_o);
    end
    a = cyc + 1;
    sb.push_back('{rdata: 32'h0, err: 1'b0, due: a + 2});
    step();
    cmd_valid = 1'b0;
    if (psel_o !== 1'b1 || penable_o !== 1'b0 || cmd_ready_o !== 1'b0) bad = 1'b1;
    if (pwrite_o !== 1'b1 || paddr_o !== 8'h10 || pwdata_o !== 32'hDEADBEEF) bad = 1'b1;
    step();
    if (psel_o !== 1'b1 || penable_o !== 1'b1) bad = 1'b1;
    if (pwrite_o !== 1'b1 || paddr_o !== 8'h10 || pwdata_o !== 32'hDEADBEEF) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL write_phases: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h, required SETUP/ACCESS with W 0x10 DEADBEEF",
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o);
    end
    step();
    tests++;
    if (psel_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL write_done: got psel=%b rsp_valid=%b, required psel=0 rsp_valid=1", psel_o, rsp_valid_o);
    end
    step();
  endtask

  task automatic test_read_wait();
    logic [31:0] a;
    int          pen_cnt;
    logic        bad;
    pen_cnt = 0;
    bad = 1'b0;
    pready = 1'b0; prdata = 32'hBAD0BAD0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'h11112222;
    a = cyc + 1;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, due: a + 6});
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (penable_o) pen_cnt++;
      if (psel_o && (paddr_o !== 8'h10 || pwrite_o !== 1'b0 || pwdata_o !== 32'h0)) bad = 1'b1;
      pready = (cyc == a + 5);
      prdata = pready ? 32'hDEADBEEF : 32'hBAD0BAD0;
      step();
    end
    pready = 1'b0;
    tests++;
    if (pen_cnt != 5) begin
      fails++;
      $display("FAIL read_penable_cycles: got %0d, required 5", pen_cnt);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL read_cmd_stable: got unstable paddr/pwrite/pwdata, required 0x10/0/0");
    end
  endtask

  task automatic test_back_to_back();
    logic        w [3];
    logic [7:0]  ad [3];
    logic [31:0] dt [3];
    int          k, psel_cnt;
    logic        prev_psel, prev_pen, acc, bad;
    w[0] = 1'b1; ad[0] = 8'h01; dt[0] = 32'h00000111;
    w[1] = 1'b1; ad[1] = 8'h02; dt[1] = 32'h00000222;
    w[2] = 1'b0; ad[2] = 8'h01; dt[2] = 32'h00000333;
    k = 0; psel_cnt = 0; prev_psel = 1'b0; prev_pen = 1'b0; bad = 1'b0;
    pready = 1'b1; prdata = 32'h5A5A0001;
    cmd_valid = 1'b1; cmd_write = w[0]; cmd_addr = ad[0]; cmd_wdata = dt[0];
    for (int c = 0; c < 12; c++) begin
      acc = cmd_valid && cmd_ready_o;
      if (acc) sb.push_back('{rdata: w[k] ? 32'h0 : 32'h5A5A0001, err: 1'b0, due: cyc + 3});
      step();
      if (psel_o) psel_cnt++;
      if (psel_o && prev_psel && penable_o === prev_pen) bad = 1'b1;
      prev_psel = psel_o;
      prev_pen  = penable_o;
      if (acc) begin
        k++;
        if (k < 3) begin
          cmd_write = w[k]; cmd_addr = ad[k]; cmd_wdata = dt[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    tests++;
    if (psel_cnt != 6) begin
      fails++;
      $display("FAIL b2b_psel_cycles: got %0d, required 6 contiguous", psel_cnt);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL b2b_penable_toggle: got repeated penable level, required alternating 0/1");
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_rsp_count: got %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a;
    int          acc_cnt;
    acc_cnt = 0;
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = 32'h0;
    a = cyc + 1;
    sb.push_back('{rdata: 32'h0, err: 1'b1, due: a + 17});
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (penable_o) acc_cnt++;
      step();
    end
    tests++;
    if (acc_cnt != 16 || psel_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_access_cycles: got %0d psel=%b, required 16 psel=0", acc_cnt, psel_o);
    end
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'hCAFEF00D;
    a = cyc + 1;
    sb.push_back('{rdata: 32'h0, err: 1'b0, due: a + 2});
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL timeout_followup: got %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_no_timeout();
    logic [31:0] a, rcyc, rdata;
    logic        got, err;
    int          acc_cnt;
    got = 1'b0; err = 1'b1; rdata = '0; rcyc = '0; acc_cnt = 0;
    z_valid = 1'b1; z_write = 1'b0; z_addr = 8'h44; z_pready = 1'b0;
    a = cyc + 1;
    step();
    z_valid = 1'b0;
    for (int i = 0; i < 140 && !got; i++) begin
      if (z_rsp_valid) begin
        got = 1'b1; rcyc = cyc; rdata = z_rsp_rdata; err = z_rsp_err;
      end else begin
        if (z_penable) acc_cnt++;
        z_pready = z_penable && (acc_cnt == 101);
        z_prdata = z_pready ? 32'h12345678 : 32'h0;
        step();
      end
    end
    z_pready = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL notimeout_rsp: got no response, required one within 140 cycles");
    end
    tests++;
    if (err !== 1'b0 || rdata !== 32'h12345678 || rcyc !== a + 102) begin
      fails++;
      $display("FAIL notimeout_data: got err=%b rdata=%h cyc=%0d, required err=0 rdata=12345678 cyc=%0d",
               err, rdata, rcyc, a + 102);
    end
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55;
    step();
    cmd_valid = 1'b0;
    step();
    tests++;
    if (penable_o !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_in_access: got penable=%b, required 1", penable_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async_drop: got psel=%b pen=%b, required 0 0", psel_o, penable_o);
    end
    @(negedge clk);
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (rsp_valid_o !== 1'b0 || psel_o !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_no_rsp: got rsp_valid=%b psel=%b, required 0 0", rsp_valid_o, psel_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_scoreboard: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
